// File: rtl/input_device_module_pkg.sv
// Shared definitions for the input device: status word layout and register select codes.
package input_device_module_pkg;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  localparam logic SEL_STATUS = 1'b0;
  localparam logic SEL_DATA   = 1'b1;

  // Assemble the CPU-visible status word; unused bits read as zero.
  function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                              input logic ovf, input logic [7:0] cnt);
    logic [31:0] s;
    s                    = '0;
    s[ST_EMPTY]          = empty;
    s[ST_FULL]           = full;
    s[ST_OVF]            = ovf;
    s[ST_CNT_LSB +: 8]   = cnt;
    return s;
  endfunction

endpackage

// File: rtl/input_device_module_sync_fifo.sv
// Small synchronous FIFO. push/pop arrive already qualified by the caller
// (no push when full without a pop, no pop when empty).
module sync_fifo_module #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  // Next-state: write at wptr, advance pointers, track occupancy.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State register; reset clears storage too so nothing stale survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign dout  = empty ? 32'h0 : mem_q[rptr_q];

endmodule

// File: rtl/input_device_module.sv
// CPU-readable input peripheral: buffers externally strobed words and exposes
// the FIFO head or a status word on the shared data/select interface.
module input_device_module
  import input_device_module_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ext_data,
  input  logic        ext_valid,
  output logic        ext_ready,
  input  logic        sel_signal,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        irq
);

  logic [31:0] fifo_dout;
  logic [AW:0] fifo_count;
  logic        fifo_empty;
  logic        fifo_full;

  logic        pop_acc;
  logic        push_acc;
  logic        ovf_set;
  logic        ovf_clr;
  logic [AW:0] count_nxt;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic [31:0] status;
  logic        unused_din;

  assign unused_din = ^{Data_in[31:3], Data_in[1:0]};

  // CPU decode and push/pop qualification; a full FIFO still accepts a word
  // when the CPU frees a slot on the same edge.
  always_comb begin
    pop_acc   = re && (sel_signal == SEL_DATA) && !fifo_empty;
    push_acc  = ext_valid && (!fifo_full || pop_acc);
    ovf_set   = ext_valid && fifo_full && !pop_acc;
    ovf_clr   = we && (sel_signal == SEL_STATUS) && Data_in[ST_OVF];
    count_nxt = fifo_count + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
  end

  sync_fifo_module #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_acc),
    .pop   (pop_acc),
    .din   (ext_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Sticky overflow; a set on the same edge as a clear takes priority.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    irq_d = (count_nxt != '0);
  end

  // Overflow flag and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= irq_d;
    end
  end

  // Read mux: status word or FIFO head (zero when empty).
  always_comb begin
    status   = pack_status(fifo_empty, fifo_full, ovf_q, 8'(fifo_count));
    Data_out = (sel_signal == SEL_DATA) ? fifo_dout : status;
  end

  assign ext_ready = !fifo_full;
  assign irq       = irq_q;

endmodule

// File: doc/input_device_module.md
Name: input_device_module

Overview:
- Memory-mapped input peripheral: the CPU-read counterpart of the output device register.
- An external source delivers 32-bit words as one-cycle strobes. The block buffers them in a small FIFO.
- The CPU reads the FIFO head or a status word through the same data/select interface used by the output device.
- Sits on the CPU data bus beside the output device and is decoded by the same address logic.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, 2..16.
- AW, 2, pointer width; log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ext_data  input  32  word from external source.
- ext_valid  input  1  one-cycle strobe: ext_data is valid this cycle. There is no back-pressure.
- ext_ready  output  1  FIFO not full; informational only.
- sel_signal  input  1  CPU register select: 0 = status, 1 = data.
- re  input  1  CPU read strobe; pops the FIFO when sel_signal=1.
- we  input  1  CPU write strobe; status write only.
- Data_in  input  32  CPU write data.
- Data_out  output  32  CPU read data, combinational.
- irq  output  1  FIFO non-empty, registered.

Behaviour:
- Reset (async, rst=1):
  - count=0, read and write pointers=0, overflow=0, irq=0.
  - Data_out shows the status word 0x00000001 (empty) when sel_signal=0, and 0x00000000 when sel_signal=1.
  - Reset mid-transfer discards all buffered data. No partial state survives.
- Status word, read with sel_signal=0:
  - bit0 = empty
  - bit1 = full
  - bit2 = overflow (sticky)
  - bits[15:8] = count, zero-extended
  - all other bits 0
- Data read, sel_signal=1:
  - Data_out = FIFO head when count>0, else 0x00000000.
  - Combinational; no wait states.
- Push: on a clk edge with ext_valid=1 and (count<DEPTH, or a pop in the same cycle), write ext_data at wptr. wptr increments modulo DEPTH.
- Pop: on a clk edge with re=1, sel_signal=1, count>0. rptr increments modulo DEPTH. The new head is visible on Data_out the next cycle.
- re with sel_signal=0 has no side effect.
- Simultaneous push and pop:
  - count>0 (including full): both happen; count unchanged; no overflow.
  - count=0: push only. The pop is ignored and Data_out was 0 that cycle.
- Overflow: ext_valid=1, count=DEPTH, and no pop in the same cycle.
  - The word is dropped and the FIFO is unchanged.
  - overflow is set to 1 on that edge.
- Overflow clear: we=1, sel_signal=0, Data_in[2]=1 clears overflow. If a set and a clear fall in the same cycle, the set wins.
- Writes with sel_signal=1 are ignored. Other Data_in bits are ignored.
- ext_ready = (count != DEPTH), derived from registered count.
- irq is registered as (next count != 0). It asserts the cycle after the first push edge and deasserts the cycle after the last pop edge.
- count is AW+1 bits; pointers wrap naturally at AW bits.

Decomposition:
- Shared package holds:
  - status bit indices: ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_CNT_LSB=8
  - select encoding: SEL_STATUS=0, SEL_DATA=1
- One natural sub-module, sync_fifo_module, parameterised by DEPTH/AW:
  - inputs: push, pop, din
  - outputs: dout, count, empty, full
  - async reset
- The top level holds the overflow flag, status mux, irq register and CPU decode.

Test Plan:
- Reset then idle -> status read = 0x00000001, data read = 0x00000000, ext_ready=1, irq=0.
- Strobe 0xA0000001 then 0xA0000002; pop twice (re=1, sel=1) -> Data_out shows 0xA0000001 then 0xA0000002. Status count goes 2, 1, 0. irq rises one cycle after the first strobe and falls one cycle after the second pop.
- Strobe 5 words (0x10..0x14) with DEPTH=4 -> status = 0x00000406 (count 4, full, overflow). Pops return 0x10..0x13; 0x14 is lost. ext_ready=0 while full.
- With FIFO full, strobe 0x55 and pop in the same cycle -> pop returns the old head, count stays 4, overflow stays 0, and 0x55 is read last.
- Set overflow, then write Data_in=0x4 with sel=0 while a new overflow event occurs -> overflow stays 1. Write 0x4 again with no event -> status bit2=0.
- Fill 3 words, assert rst for one cycle asynchronously (mid-cycle) -> status immediately 0x00000001. A subsequent strobe of 0xBEEF is read first; wrap-around is checked by 10 push/pop cycles returning data in order.
